// File: rtl/synth_note_pkg.sv
// Shared constants for the PS/2 note front end: note codes, octave limits,
// scan-code set 2 values, byte-FSM states and the key-to-note map.
package synth_note_pkg;

    localparam logic [3:0] NOTE_C  = 4'd0;
    localparam logic [3:0] NOTE_CS = 4'd1;
    localparam logic [3:0] NOTE_D  = 4'd2;
    localparam logic [3:0] NOTE_DS = 4'd3;
    localparam logic [3:0] NOTE_E  = 4'd4;
    localparam logic [3:0] NOTE_F  = 4'd5;
    localparam logic [3:0] NOTE_FS = 4'd6;
    localparam logic [3:0] NOTE_G  = 4'd7;
    localparam logic [3:0] NOTE_GS = 4'd8;
    localparam logic [3:0] NOTE_A  = 4'd9;
    localparam logic [3:0] NOTE_AS = 4'd10;
    localparam logic [3:0] NOTE_B  = 4'd11;

    localparam logic [2:0] OCTAVE_MIN = 3'd0;
    localparam logic [2:0] OCTAVE_MAX = 3'd6;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_OCT_DOWN = 8'h1A;  // Z
    localparam logic [7:0] SC_OCT_UP   = 8'h22;  // X
    localparam logic [7:0] SC_KEY_A    = 8'h1C;
    localparam logic [7:0] SC_KEY_W    = 8'h1D;
    localparam logic [7:0] SC_KEY_S    = 8'h1B;
    localparam logic [7:0] SC_KEY_E    = 8'h24;
    localparam logic [7:0] SC_KEY_D    = 8'h23;
    localparam logic [7:0] SC_KEY_F    = 8'h2B;
    localparam logic [7:0] SC_KEY_T    = 8'h2C;
    localparam logic [7:0] SC_KEY_G    = 8'h34;
    localparam logic [7:0] SC_KEY_Y    = 8'h35;
    localparam logic [7:0] SC_KEY_H    = 8'h33;
    localparam logic [7:0] SC_KEY_U    = 8'h3C;
    localparam logic [7:0] SC_KEY_J    = 8'h3B;
    localparam logic [7:0] SC_KEY_K    = 8'h42;

    typedef enum logic [1:0] {
        BS_NORMAL,
        BS_BREAK,
        BS_EXT,
        BS_EXT_BREAK
    } byte_state_t;

    typedef struct packed {
        logic       hit;
        logic [3:0] note;
        logic       up;    // key sounds one octave above octave_sel
    } key_map_t;

    function automatic key_map_t map_key(input logic [7:0] code);
        key_map_t m;
        m = '{hit: 1'b1, note: NOTE_C, up: 1'b0};
        case (code)
            SC_KEY_A: m.note = NOTE_C;
            SC_KEY_W: m.note = NOTE_CS;
            SC_KEY_S: m.note = NOTE_D;
            SC_KEY_E: m.note = NOTE_DS;
            SC_KEY_D: m.note = NOTE_E;
            SC_KEY_F: m.note = NOTE_F;
            SC_KEY_T: m.note = NOTE_FS;
            SC_KEY_G: m.note = NOTE_G;
            SC_KEY_Y: m.note = NOTE_GS;
            SC_KEY_H: m.note = NOTE_A;
            SC_KEY_U: m.note = NOTE_AS;
            SC_KEY_J: m.note = NOTE_B;
            SC_KEY_K: m.up   = 1'b1;
            default:  m.hit  = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_rx_byte.sv
// PS/2 frame receiver: synchroniser, falling-edge detect, frame FSM and timeout.
// Odd-parity checking is compiled in only when PS2_PARITY_CHECK_EN is defined.
module ps2_rx_byte #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       byte_valid,
    output logic [7:0] rx_byte,
    output logic       err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    rx_state_t   state_reg;
    logic [2:0]  clk_sync_reg;
    logic [1:0]  dat_sync_reg;
    logic [2:0]  bit_cnt_reg;
    logic [7:0]  shift_reg;
    logic [7:0]  byte_reg;
    logic [TW-1:0] to_cnt_reg;
    logic        valid_reg;
    logic        err_reg;
    logic        fall;
    logic        dat;
    logic        parity_bad;

    // Bit 2 is the previous synchronised level, used only for edge detection.
    assign fall = clk_sync_reg[2] & ~clk_sync_reg[1];
    assign dat  = dat_sync_reg[1];

`ifdef PS2_PARITY_CHECK_EN
    logic par_reg;
    assign parity_bad = ~(^{shift_reg, par_reg});
`else
    assign parity_bad = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_reg <= 3'b111;
            dat_sync_reg <= 2'b11;
            state_reg    <= RX_IDLE;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            byte_reg     <= '0;
            to_cnt_reg   <= '0;
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            par_reg      <= 1'b0;
`endif
        end else begin
            clk_sync_reg <= {clk_sync_reg[1:0], ps2_clk};
            dat_sync_reg <= {dat_sync_reg[0], ps2_dat};
            valid_reg    <= 1'b0;
            err_reg      <= 1'b0;
            if (fall) begin
                to_cnt_reg <= '0;
                case (state_reg)
                    RX_IDLE: begin
                        if (!dat) begin
                            state_reg   <= RX_DATA;
                            bit_cnt_reg <= '0;
                        end else begin
                            err_reg <= 1'b1;
                        end
                    end
                    RX_DATA: begin
                        shift_reg   <= {dat, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) state_reg <= RX_PARITY;
                    end
                    RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        par_reg <= dat;
`endif
                        state_reg <= RX_STOP;
                    end
                    default: begin
                        state_reg <= RX_IDLE;
                        if (!dat || parity_bad) begin
                            err_reg <= 1'b1;
                        end else begin
                            valid_reg <= 1'b1;
                            byte_reg  <= shift_reg;
                        end
                    end
                endcase
            end else if (state_reg != RX_IDLE) begin
                if (to_cnt_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_reg    <= 1'b1;
                    state_reg  <= RX_IDLE;
                    to_cnt_reg <= '0;
                end else begin
                    to_cnt_reg <= to_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign byte_valid = valid_reg;
    assign rx_byte    = byte_reg;
    assign err        = err_reg;

endmodule

// File: rtl/ps2_note_sender.sv
// PS/2 keyboard to note-event front end: prefix tracking, key map, octave
// selection and held-key tracking. Parity checking via PS2_PARITY_CHECK_EN.
import synth_note_pkg::*;

module ps2_note_sender #(
    parameter int         TIMEOUT_CYCLES = 50000,
    parameter logic [2:0] DEFAULT_OCTAVE = 3'd4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic       note_in,
    output logic [3:0] note,
    output logic [2:0] octave,
    output logic [2:0] octave_sel,
    output logic       key_held,
    output logic       frame_err
);
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_err;
    key_map_t    map;
    byte_state_t bstate_reg;
    logic [7:0]  cur_key_reg;
    logic        note_in_reg;
    logic [3:0]  note_reg;
    logic [2:0]  octave_reg;
    logic [2:0]  octave_sel_reg;
    logic        key_held_reg;
    logic        frame_err_reg;
    logic        make_ok;

    ps2_rx_byte #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .byte_valid (rx_valid),
        .rx_byte    (rx_byte),
        .err        (rx_err)
    );

    assign map = map_key(rx_byte);
    // A make produces an event unless K would overflow the top octave or it is
    // a typematic repeat of the key already sounding.
    assign make_ok = map.hit
                   && !(map.up && octave_sel_reg == OCTAVE_MAX)
                   && !(key_held_reg && rx_byte == cur_key_reg);

    always_ff @(posedge clk) begin
        if (reset) begin
            bstate_reg     <= BS_NORMAL;
            cur_key_reg    <= '0;
            note_in_reg    <= 1'b0;
            note_reg       <= NOTE_C;
            octave_reg     <= DEFAULT_OCTAVE;
            octave_sel_reg <= DEFAULT_OCTAVE;
            key_held_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            note_in_reg   <= 1'b0;
            frame_err_reg <= 1'b0;
            if (rx_err) begin
                frame_err_reg <= 1'b1;
            end else if (rx_valid) begin
                case (bstate_reg)
                    BS_NORMAL: begin
                        if (rx_byte == SC_BREAK) begin
                            bstate_reg <= BS_BREAK;
                        end else if (rx_byte == SC_EXT) begin
                            bstate_reg <= BS_EXT;
                        end else if (rx_byte == SC_OCT_DOWN) begin
                            if (octave_sel_reg != OCTAVE_MIN) octave_sel_reg <= octave_sel_reg - 3'd1;
                        end else if (rx_byte == SC_OCT_UP) begin
                            if (octave_sel_reg != OCTAVE_MAX) octave_sel_reg <= octave_sel_reg + 3'd1;
                        end else if (make_ok) begin
                            note_reg     <= map.note;
                            octave_reg   <= octave_sel_reg + {2'b00, map.up};
                            note_in_reg  <= 1'b1;
                            key_held_reg <= 1'b1;
                            cur_key_reg  <= rx_byte;
                        end
                    end
                    BS_BREAK: begin
                        if (rx_byte == cur_key_reg) key_held_reg <= 1'b0;
                        bstate_reg <= BS_NORMAL;
                    end
                    BS_EXT: begin
                        bstate_reg <= (rx_byte == SC_BREAK) ? BS_EXT_BREAK : BS_NORMAL;
                    end
                    default: bstate_reg <= BS_NORMAL;
                endcase
            end
        end
    end

    assign note_in    = note_in_reg;
    assign note       = note_reg;
    assign octave     = octave_reg;
    assign octave_sel = octave_sel_reg;
    assign key_held   = key_held_reg;
    assign frame_err  = frame_err_reg;

endmodule
